fetch_stage: RTL and testbench

//  MIPS IF stage plus IF/ID pipeline register. Sits directly upstream of HazardDetectionUnit and consumes its Stall and Flush.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_id_register.sv | 38 +++
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and next-PC select encoding for the MIPS front end.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000;
  localparam logic [DATA_WIDTH-1:0] NOP      = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    PCSEL_SEQ  = 2'd0,
    PCSEL_BR   = 2'd1,
    PCSEL_J    = 2'd2,
    PCSEL_HOLD = 2'd3
  } pcsel_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads on en, inserts a bubble on clr, holds otherwise.
module if_id_register #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] NOP = mips_pkg::NOP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc4,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc4,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc4;
  logic                  r_valid;

  // clr takes precedence over en so a redirect squashes even a stalled slot
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_instr <= NOP;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC mux, IF/ID register and saturating
// stall/redirect event counters.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP = mips_pkg::NOP,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] JumpTarget,
  input  logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] InstrAddr,
  output logic [DATA_WIDTH-1:0] IF_ID_Instruction,
  output logic [DATA_WIDTH-1:0] IF_ID_PC4,
  output logic                  IF_ID_Valid,
  output logic [CNT_WIDTH-1:0]  StallCount,
  output logic [CNT_WIDTH-1:0]  FlushCount
);

  import mips_pkg::*;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_flush_cnt;

  pcsel_e                w_pcsel;
  logic [DATA_WIDTH-1:0] w_pc4;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic                  w_redirect;
  logic                  w_ifid_en;
  logic                  w_unused_lsbs;

  // Targets are word-aligned; their two low bits are deliberately dropped
  assign w_unused_lsbs = &{1'b0, BranchTarget[1:0], JumpTarget[1:0]};

  assign w_pc4      = r_pc + DATA_WIDTH'(PC_INC);
  assign w_redirect = Flush | Jump;
  assign w_ifid_en  = ~Stall | w_redirect;

  // Priority: Flush > Jump > Stall > sequential
  always_comb begin
    w_pcsel = PCSEL_SEQ;
    if (Flush)      w_pcsel = PCSEL_BR;
    else if (Jump)  w_pcsel = PCSEL_J;
    else if (Stall) w_pcsel = PCSEL_HOLD;
  end

  always_comb begin
    w_next_pc = w_pc4;
    case (w_pcsel)
      PCSEL_BR:   w_next_pc = {BranchTarget[DATA_WIDTH-1:2], 2'b00};
      PCSEL_J:    w_next_pc = {JumpTarget[DATA_WIDTH-1:2], 2'b00};
      PCSEL_HOLD: w_next_pc = r_pc;
      default:    w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_next_pc;
  end

  // Saturating counters: stall counts only when the stall actually holds the PC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pcsel == PCSEL_HOLD && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_redirect && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  if_id_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP        (NOP)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .en      (w_ifid_en),
    .clr     (w_redirect),
    .i_instr (Instruction),
    .i_pc4   (w_pc4),
    .o_instr (IF_ID_Instruction),
    .o_pc4   (IF_ID_PC4),
    .o_valid (IF_ID_Valid)
  );

  assign InstrAddr  = r_pc;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default instance, a wrap-around reset PC
// instance and a narrow-counter instance share the same stimulus.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Flush;
  logic        Jump;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] Instruction;

  logic [31:0] addr, instr, pc4;
  logic        valid;
  logic [15:0] scnt, fcnt;

  logic [31:0] w_addr, w_instr, w_pc4;
  logic        w_valid;
  logic [15:0] w_scnt, w_fcnt;

  logic [31:0] s_addr, s_instr, s_pc4;
  logic        s_valid;
  logic [1:0]  s_scnt, s_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Instruction(Instruction), .InstrAddr(addr), .IF_ID_Instruction(instr),
    .IF_ID_PC4(pc4), .IF_ID_Valid(valid), .StallCount(scnt), .FlushCount(fcnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Instruction(Instruction), .InstrAddr(w_addr), .IF_ID_Instruction(w_instr),
    .IF_ID_PC4(w_pc4), .IF_ID_Valid(w_valid), .StallCount(w_scnt), .FlushCount(w_fcnt)
  );

  fetch_stage #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Instruction(Instruction), .InstrAddr(s_addr), .IF_ID_Instruction(s_instr),
    .IF_ID_PC4(s_pc4), .IF_ID_Valid(s_valid), .StallCount(s_scnt), .FlushCount(s_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_addr,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4,
                        input logic e_valid);
    chk({tag, ".addr"},  addr,  e_addr);
    chk({tag, ".instr"}, instr, e_instr);
    chk({tag, ".pc4"},   pc4,   e_pc4);
    chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Jump = 1'b0;
    BranchTarget = '0; JumpTarget = '0; Instruction = 32'h2401_0001;

    // Reset held for two cycles
    step(); step();
    chk_if("rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    chk("rst.scnt", 32'(scnt), 32'h0);
    chk("rst.fcnt", 32'(fcnt), 32'h0);
    chk("rst_w.addr", w_addr, 32'hFFFF_FFFC);

    // Normal fetch
    reset = 1'b0;
    step();
    chk_if("seq1", 32'h0040_0004, 32'h2401_0001, 32'h0040_0004, 1'b1);
    chk("wrap.addr", w_addr, 32'h0000_0000);
    chk("wrap.pc4", w_pc4, 32'h0000_0000);
    Instruction = 32'h2402_0002;
    step();
    chk_if("seq2", 32'h0040_0008, 32'h2402_0002, 32'h0040_0008, 1'b1);

    // Stall for two cycles holds PC and IF/ID
    Stall = 1'b1; Instruction = 32'h2403_0003;
    step();
    chk_if("stall1", 32'h0040_0008, 32'h2402_0002, 32'h0040_0008, 1'b1);
    step();
    chk_if("stall2", 32'h0040_0008, 32'h2402_0002, 32'h0040_0008, 1'b1);
    chk("stall2.scnt", 32'(scnt), 32'd2);
    Stall = 1'b0;
    step();
    chk_if("unstall", 32'h0040_000C, 32'h2403_0003, 32'h0040_000C, 1'b1);

    // Taken branch
    Flush = 1'b1; BranchTarget = 32'h0040_0100; Instruction = 32'h8C08_0000;
    step();
    chk_if("flush", 32'h0040_0100, 32'h0, 32'h0, 1'b0);
    chk("flush.fcnt", 32'(fcnt), 32'd1);
    Flush = 1'b0; Instruction = 32'h2404_0004;
    step();
    chk_if("target", 32'h0040_0104, 32'h2404_0004, 32'h0040_0104, 1'b1);

    // Flush overrides Stall; low target bits cleared
    Flush = 1'b1; Stall = 1'b1; BranchTarget = 32'h0040_0203;
    step();
    chk_if("flushstall", 32'h0040_0200, 32'h0, 32'h0, 1'b0);
    chk("flushstall.scnt", 32'(scnt), 32'd2);
    chk("flushstall.fcnt", 32'(fcnt), 32'd2);

    // Flush beats Jump
    Stall = 1'b0; Jump = 1'b1; JumpTarget = 32'h0040_0300; BranchTarget = 32'h0040_0400;
    step();
    chk("flushjump.addr", addr, 32'h0040_0400);
    chk("flushjump.fcnt", 32'(fcnt), 32'd3);

    // Jump alone beats Stall
    Flush = 1'b0; Stall = 1'b1; JumpTarget = 32'h0040_0302;
    step();
    chk_if("jump", 32'h0040_0300, 32'h0, 32'h0, 1'b0);
    chk("jump.fcnt", 32'(fcnt), 32'd4);
    chk("jump.scnt", 32'(scnt), 32'd2);
    chk("sat.fcnt2", 32'(s_fcnt), 32'd3);

    Jump = 1'b0; Stall = 1'b0; Instruction = 32'h2405_0005;
    step();
    chk_if("seq3", 32'h0040_0304, 32'h2405_0005, 32'h0040_0304, 1'b1);

    // Long stall: 2-bit counter saturates, 16-bit keeps counting
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("sat.scnt2", 32'(s_scnt), 32'd3);
    chk("long.scnt", 32'(scnt), 32'd7);
    chk_if("long", 32'h0040_0304, 32'h2405_0005, 32'h0040_0304, 1'b1);

    // Reset wins over Stall and Flush
    reset = 1'b1; Flush = 1'b1; BranchTarget = 32'h0040_0500;
    step();
    chk_if("rst2", 32'h0040_0000, 32'h0, 32'h0, 1'b0);
    chk("rst2.scnt", 32'(scnt), 32'h0);
    chk("rst2.fcnt", 32'(fcnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
